// File: rtl/quiz_round_sequencer.sv
// ---- quiz_round_sequencer : game-round controller for random question addressing ----
// ---- rev 1.0 ----
`default_nettype none

module quiz_round_sequencer #(
  parameter int NUM_ROUNDS  = 8,
  parameter int ROUND_TICKS = 100,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       tick_100ms,
  input  logic [1:0] rand_addr,
  input  logic       answer_valid,
  input  logic       answer_correct,
  output logic       gen_enable,
  output logic       force_change,
  output logic [1:0] ram_addr,
  output logic       question_valid,
  output logic [3:0] score,
  output logic [3:0] round_num,
  output logic [6:0] time_left,
  output logic       game_over
);

  localparam int              RW          = $clog2(MAX_RETRY + 2);
  localparam logic [RW-1:0]   RETRY_LIMIT = RW'(MAX_RETRY);
  localparam logic [3:0]      LAST_ROUND  = 4'(NUM_ROUNDS);
  localparam logic [6:0]      TICKS_INIT  = 7'(ROUND_TICKS);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_ASK    = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]    state_q, state_d;
  logic          settle_q, settle_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [1:0]    prev_q, prev_d;
  logic [1:0]    ram_q, ram_d;
  logic [3:0]    score_q, score_d;
  logic [3:0]    round_q, round_d;
  logic [6:0]    time_q, time_d;
  logic          fc_q, qv_q, ge_q, go_q;
  logic          round_end;

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    retry_d   = retry_q;
    prev_d    = prev_q;
    ram_d     = ram_q;
    score_d   = score_q;
    round_d   = round_q;
    time_d    = time_q;
    round_end = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          score_d = 4'd0;
          round_d = 4'd1;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        settle_d = 1'b0;
        state_d  = S_SETTLE;
      end

      S_SETTLE: begin
        if (settle_q) begin
          state_d = S_CHECK;
        end else begin
          settle_d = 1'b1;
        end
      end

      S_CHECK: begin
        // A repeat is re-requested at most RETRY_LIMIT times, then accepted as-is
        if ((round_q > 4'd1) && (rand_addr == prev_q) && (retry_q < RETRY_LIMIT)) begin
          retry_d = retry_q + 1'b1;
          state_d = S_REQ;
        end else begin
          ram_d   = rand_addr;
          prev_d  = rand_addr;
          retry_d = '0;
          time_d  = TICKS_INIT;
          state_d = S_ASK;
        end
      end

      S_ASK: begin
        // An answer wins over a simultaneous final tick, so time_left holds
        if (answer_valid) begin
          round_end = 1'b1;
          if (answer_correct && (score_q != 4'd15)) begin
            score_d = score_q + 4'd1;
          end
        end else if (tick_100ms) begin
          time_d = time_q - 7'd1;
          if (time_q == 7'd1) begin
            round_end = 1'b1;
          end
        end

        if (round_end) begin
          if (round_q >= LAST_ROUND) begin
            state_d = S_DONE;
          end else begin
            round_d = round_q + 4'd1;
            state_d = S_REQ;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes are registered from the next state so they align with the state they describe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      settle_q <= 1'b0;
      retry_q  <= '0;
      prev_q   <= 2'd0;
      ram_q    <= 2'd0;
      score_q  <= 4'd0;
      round_q  <= 4'd0;
      time_q   <= 7'd0;
      fc_q     <= 1'b0;
      qv_q     <= 1'b0;
      ge_q     <= 1'b0;
      go_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      retry_q  <= retry_d;
      prev_q   <= prev_d;
      ram_q    <= ram_d;
      score_q  <= score_d;
      round_q  <= round_d;
      time_q   <= time_d;
      fc_q     <= (state_d == S_REQ);
      qv_q     <= (state_d == S_ASK);
      ge_q     <= (state_d == S_ASK);
      go_q     <= (state_d == S_DONE);
    end
  end

  assign gen_enable     = ge_q;
  assign force_change   = fc_q;
  assign ram_addr       = ram_q;
  assign question_valid = qv_q;
  assign score          = score_q;
  assign round_num      = round_q;
  assign time_left      = time_q;
  assign game_over      = go_q;

endmodule

`default_nettype wire

// File: tb/tb_quiz_round_sequencer.sv
// ---- tb_quiz_round_sequencer : directed, table-driven bench for quiz_round_sequencer ----
// ---- rev 1.0 ----
`default_nettype none

module tb_quiz_round_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, tick, av, ac;
  logic [1:0] ra;
  logic       ge, fc, qv, go;
  logic [1:0] ram;
  logic [3:0] sc, rn;
  logic [6:0] tl;

  logic       start2, tick2, av2, ac2;
  logic [1:0] ra2;
  logic       ge2, fc2, qv2, go2;
  logic [1:0] ram2;
  logic [3:0] sc2, rn2;
  logic [6:0] tl2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  quiz_round_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .tick_100ms(tick), .rand_addr(ra),
    .answer_valid(av), .answer_correct(ac), .gen_enable(ge), .force_change(fc),
    .ram_addr(ram), .question_valid(qv), .score(sc), .round_num(rn),
    .time_left(tl), .game_over(go)
  );

  quiz_round_sequencer #(.NUM_ROUNDS(2), .ROUND_TICKS(5), .MAX_RETRY(3)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .tick_100ms(tick2), .rand_addr(ra2),
    .answer_valid(av2), .answer_correct(ac2), .gen_enable(ge2), .force_change(fc2),
    .ram_addr(ram2), .question_valid(qv2), .score(sc2), .round_num(rn2),
    .time_left(tl2), .game_over(go2)
  );

  typedef struct {
    logic       st;
    logic       tk;
    logic [1:0] ra;
    logic       av;
    logic       ac;
    logic       e_fc;
    logic       e_qv;
    logic       e_ge;
    logic [1:0] e_ram;
    logic [3:0] e_sc;
    logic [3:0] e_rn;
    logic [6:0] e_tl;
    logic       e_go;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".fc"},  32'(fc),  0);
    chk({tag, ".qv"},  32'(qv),  0);
    chk({tag, ".ge"},  32'(ge),  0);
    chk({tag, ".ram"}, 32'(ram), 0);
    chk({tag, ".sc"},  32'(sc),  0);
    chk({tag, ".rn"},  32'(rn),  0);
    chk({tag, ".tl"},  32'(tl),  0);
    chk({tag, ".go"},  32'(go),  0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
    end
    tick = 1'b0;
  endtask

  // Runs until question_valid of the chosen instance rises, counting force_change pulses
  task automatic wait_qv(input bit sel, input int budget, output int cycles, output int pulses);
    logic q, f;
    cycles = 0;
    pulses = 0;
    q = 1'b0;
    while (!q && cycles < budget) begin
      cyc();
      start  = 1'b0;
      start2 = 1'b0;
      cycles++;
      f = sel ? fc2 : fc;
      q = sel ? qv2 : qv;
      if (f) pulses++;
    end
    if (!q) chk("wait_qv_timeout", 32'(cycles), 32'(budget + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, p;
    rst = 1'b0; start = 0; tick = 0; av = 0; ac = 0; ra = 2'd2;
    start2 = 0; tick2 = 0; av2 = 0; ac2 = 0; ra2 = 2'd0;

    //           st    tk    ra    av    ac    fc    qv    ge    ram    sc    rn    tl      go
    tbl[0] = '{1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 4'd1, 7'd0,   1'b0};
    tbl[1] = '{1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd1, 7'd0,   1'b0};
    tbl[2] = '{1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd1, 7'd0,   1'b0};
    tbl[3] = '{1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd1, 7'd0,   1'b0};
    tbl[4] = '{1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 4'd0, 4'd1, 7'd100, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 4'd0, 4'd1, 7'd99,  1'b0};
    tbl[6] = '{1'b0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 4'd1, 4'd2, 7'd99,  1'b0};

    cyc();
    cyc();
    chk_zero("reset");
    chk("reset.go2", 32'(go2), 0);
    chk("reset.rn2", 32'(rn2), 0);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      start = tbl[i].st; tick = tbl[i].tk; ra = tbl[i].ra; av = tbl[i].av; ac = tbl[i].ac;
      cyc();
      chk($sformatf("v%0d.fc", i),  32'(fc),  32'(tbl[i].e_fc));
      chk($sformatf("v%0d.qv", i),  32'(qv),  32'(tbl[i].e_qv));
      chk($sformatf("v%0d.ge", i),  32'(ge),  32'(tbl[i].e_ge));
      chk($sformatf("v%0d.ram", i), 32'(ram), 32'(tbl[i].e_ram));
      chk($sformatf("v%0d.sc", i),  32'(sc),  32'(tbl[i].e_sc));
      chk($sformatf("v%0d.rn", i),  32'(rn),  32'(tbl[i].e_rn));
      chk($sformatf("v%0d.tl", i),  32'(tl),  32'(tbl[i].e_tl));
      chk($sformatf("v%0d.go", i),  32'(go),  32'(tbl[i].e_go));
    end
    start = 0; tick = 0; av = 0; ac = 0;

    // Round 2 repeats address 2: three retries beyond the initial request, then accepted
    wait_qv(1'b0, 40, c, p);
    chk("retry.cycles", 32'(c), 16);
    chk("retry.pulses", 32'(p), 3);
    chk("retry.ram", 32'(ram), 2);
    chk("retry.rn",  32'(rn), 2);
    chk("retry.tl",  32'(tl), 100);

    ticks(99);
    chk("r2.tl_at_1", 32'(tl), 1);
    chk("r2.qv_at_1", 32'(qv), 1);
    tick = 1; av = 1; ac = 1;
    cyc();
    tick = 0; av = 0; ac = 0; ra = 2'd1;
    chk("tie.sc", 32'(sc), 2);
    chk("tie.tl", 32'(tl), 1);
    chk("tie.rn", 32'(rn), 3);
    chk("tie.fc", 32'(fc), 1);
    chk("tie.qv", 32'(qv), 0);

    wait_qv(1'b0, 20, c, p);
    chk("r3.cycles", 32'(c), 4);
    chk("r3.pulses", 32'(p), 0);
    chk("r3.ram", 32'(ram), 1);
    chk("r3.rn",  32'(rn), 3);
    chk("r3.sc",  32'(sc), 2);

    ticks(2);
    chk("r3.tl98", 32'(tl), 98);
    rst = 1'b0;
    #2;
    chk_zero("async_rst");
    cyc();
    rst = 1'b1;

    start = 1;
    wait_qv(1'b0, 20, c, p);
    chk("restart.cycles", 32'(c), 5);
    chk("restart.pulses", 32'(p), 1);
    chk("restart.rn",  32'(rn), 1);
    chk("restart.sc",  32'(sc), 0);
    chk("restart.ram", 32'(ram), 1);

    ra = 2'd3;
    ticks(99);
    chk("to.tl1", 32'(tl), 1);
    ticks(1);
    chk("to.tl0", 32'(tl), 0);
    chk("to.sc",  32'(sc), 0);
    chk("to.rn",  32'(rn), 2);
    chk("to.fc",  32'(fc), 1);
    chk("to.qv",  32'(qv), 0);

    av = 1; ac = 1; start = 1;
    cyc();
    av = 0; ac = 0; start = 0;
    chk("ign.sc", 32'(sc), 0);
    chk("ign.rn", 32'(rn), 2);
    chk("ign.fc", 32'(fc), 0);
    wait_qv(1'b0, 20, c, p);
    chk("ign.cycles", 32'(c), 3);
    chk("ign.ram", 32'(ram), 3);

    // Two-round instance: full game, then restart from DONE
    start2 = 1;
    wait_qv(1'b1, 20, c, p);
    chk("g2.r1.cycles", 32'(c), 5);
    chk("g2.r1.tl", 32'(tl2), 5);
    chk("g2.r1.rn", 32'(rn2), 1);
    av2 = 1; ac2 = 1;
    cyc();
    av2 = 0; ac2 = 0; ra2 = 2'd3;
    chk("g2.r1.sc", 32'(sc2), 1);
    chk("g2.r1.fc", 32'(fc2), 1);
    chk("g2.r2.rn", 32'(rn2), 2);
    wait_qv(1'b1, 20, c, p);
    chk("g2.r2.cycles", 32'(c), 4);
    chk("g2.r2.ram", 32'(ram2), 3);
    av2 = 1; ac2 = 1;
    cyc();
    av2 = 0; ac2 = 0;
    chk("g2.done.go", 32'(go2), 1);
    chk("g2.done.sc", 32'(sc2), 2);
    chk("g2.done.rn", 32'(rn2), 2);
    chk("g2.done.qv", 32'(qv2), 0);
    chk("g2.done.fc", 32'(fc2), 0);
    av2 = 1; ac2 = 1;
    cyc();
    av2 = 0; ac2 = 0;
    chk("g2.hold.go", 32'(go2), 1);
    chk("g2.hold.sc", 32'(sc2), 2);
    start2 = 1;
    cyc();
    start2 = 0;
    chk("g2.rs.go", 32'(go2), 0);
    chk("g2.rs.sc", 32'(sc2), 0);
    chk("g2.rs.rn", 32'(rn2), 1);
    chk("g2.rs.fc", 32'(fc2), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
